// File: rtl/micro_exec_ctrl.sv
// micro_exec_ctrl: sequences one micro command through optional data-memory access and writeback/redirect.
module micro_exec_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [13:0] micro_cmd,
    input  logic [31:0] alu_res,
    input  logic [31:0] rs2_data,
    input  logic [31:0] pc,
    input  logic        br_taken,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        rf_wen,
    output logic [31:0] rf_wdata,
    output logic        pc_jump,
    output logic [31:0] pc_target,
    output logic        done,
    output logic        err
);
    typedef enum logic [1:0] {IDLE, MEM, WB} state_t;
    state_t state, state_nx;
    logic [13:0] cmd_q;
    logic [31:0] alu_q, rs2_q, pc_q, load_q, lane;
    logic        br_q, err_q;
    logic [7:0]  cnt;
    logic        accept, fault, timeout_hit;
    logic [1:0]  in_rd, in_wr, in_sz, rd_q, wr_q;
    logic        unused_ok;
    assign in_rd       = micro_cmd[8:7];
    assign in_wr       = micro_cmd[10:9];
    assign in_sz       = in_rd | in_wr;
    assign rd_q        = cmd_q[8:7];
    assign wr_q        = cmd_q[10:9];
    assign accept      = cmd_valid & cmd_ready;
    assign fault       = (|in_rd & |in_wr) | (in_sz == 2'd2 & alu_res[0]) | (in_sz == 2'd3 & |alu_res[1:0]);
    assign timeout_hit = cnt == 8'(TIMEOUT - 1);
    assign unused_ok   = ^{cmd_q[6:4], cmd_q[2:0]};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = (|in_sz && !fault) ? MEM : WB;
            MEM:     if (mem_ack || timeout_hit) state_nx = WB;
            WB:      state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    // Read data is aligned to bit 0 before sign/zero extension.
    assign lane = mem_rdata >> {alu_q[1:0], 3'b000};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q  <= '0;
            alu_q  <= '0;
            rs2_q  <= '0;
            pc_q   <= '0;
            br_q   <= 1'b0;
            err_q  <= 1'b0;
            load_q <= '0;
            cnt    <= '0;
        end else if (accept) begin
            cmd_q <= micro_cmd;
            alu_q <= alu_res;
            rs2_q <= rs2_data;
            pc_q  <= pc;
            br_q  <= br_taken;
            err_q <= fault;
            cnt   <= '0;
        end else if (state == MEM) begin
            if (mem_ack)
                load_q <= rd_q == 2'd1 ? {{24{~cmd_q[3] & lane[7]}}, lane[7:0]} :
                          rd_q == 2'd2 ? {{16{~cmd_q[3] & lane[15]}}, lane[15:0]} : lane;
            else begin
                cnt <= cnt + 8'd1;
                if (timeout_hit) err_q <= 1'b1;
            end
        end
    end
    assign cmd_ready = state == IDLE;
    assign mem_req   = state == MEM;
    assign mem_we    = mem_req & |wr_q;
    assign mem_addr  = {alu_q[31:2], 2'b00};
    assign mem_wstrb = wr_q == 2'd1 ? 4'b0001 << alu_q[1:0] :
                       wr_q == 2'd2 ? 4'b0011 << alu_q[1:0] :
                       wr_q == 2'd3 ? 4'b1111 : 4'b0000;
    assign mem_wdata = wr_q == 2'd1 ? {4{rs2_q[7:0]}} : wr_q == 2'd2 ? {2{rs2_q[15:0]}} : rs2_q;
    assign done      = state == WB;
    assign err       = done & err_q;
    assign rf_wen    = done & cmd_q[13] & ~err_q;
    assign rf_wdata  = (cmd_q[13] & cmd_q[12]) ? pc_q + 32'd4 : |rd_q ? load_q : alu_q;
    assign pc_jump   = done & cmd_q[12] & ~err_q & (cmd_q[13] | br_q);
    assign pc_target = cmd_q[11] ? alu_q : {alu_q[31:1], 1'b0};
endmodule

// File: doc/micro_exec_ctrl.md
MICRO_EXEC_CTRL -- requirements
Module: micro_exec_ctrl

Interface
REQ-001 Parameter: TIMEOUT, 255, maximum cycles waited for mem_ack in MEM (range 1..255, 8-bit counter).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 cmd_valid  in  1  micro command and operands valid.
REQ-005 cmd_ready  out  1  block can accept a command (high only in IDLE).
REQ-006 micro_cmd  in  14  [13]REGEN [12]PCJEN [11]PCREN [10:9]MWEN [8:7]MREN [6:4]ALUOP [3]UNSIGN [2:0]IMM_TYPE; MWEN/MREN 00 none, 01 byte, 10 half, 11 word.
REQ-007 alu_res  in  32  ALU result: memory address, jump target or writeback value.
REQ-008 rs2_data  in  32  store data source.
REQ-009 pc  in  32  PC of the command.
REQ-010 br_taken  in  1  branch condition, meaningful when PCJEN=1 and REGEN=0.
REQ-011 mem_req, mem_we  out  1 each  request and write-enable toward data memory.
REQ-012 mem_addr  out  32  {addr[31:2],2'b00}; mem_wstrb out 4; mem_wdata out 32.
REQ-013 mem_ack  in  1; mem_rdata  in  32  response handshake and read word.
REQ-014 rf_wen  out  1; rf_wdata  out  32  register-file writeback.
REQ-015 pc_jump  out  1; pc_target  out  32  redirect request.
REQ-016 done  out  1; err  out  1  one-cycle completion pulse and error qualifier.

Function
REQ-017 States IDLE, MEM, WB; IDLE->MEM on accept with MREN or MWEN nonzero and no fault; IDLE->WB on accept otherwise; MEM->WB on mem_ack or timeout; WB->IDLE unconditionally.
REQ-018 Accept = cmd_valid & cmd_ready; micro_cmd, alu_res, rs2_data, pc, br_taken captured into registers on accept; inputs ignored in MEM and WB.
REQ-019 Fault at accept: MREN and MWEN both nonzero; half access with alu_res[0]=1; word access with alu_res[1:0]!=0 -> go WB with err=1, no mem_req, rf_wen=0, pc_jump=0.
REQ-020 MEM: mem_req=1 held every cycle until mem_ack sampled high; mem_addr/mem_we/mem_wstrb/mem_wdata stable throughout.
REQ-021 Store strobe: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111; mem_wdata = rs2 byte replicated x4 (byte), halfword x2 (half), rs2 (word).
REQ-022 Load: lane = mem_rdata >> (8*addr[1:0]), captured on the ack cycle; byte/half sign-extended when UNSIGN=0, zero-extended when UNSIGN=1; word unchanged.
REQ-023 Timeout: 8-bit counter cleared on MEM entry, +1 per MEM cycle without ack; reaching TIMEOUT -> WB with err=1, no writeback; ack in the same cycle as terminal count wins (no error).
REQ-024 mem_ack outside MEM ignored.
REQ-025 WB (one cycle): done=1; rf_wen=REGEN & !err; rf_wdata = pc+4 if REGEN&PCJEN, loaded value if MREN!=0, else alu_res.
REQ-026 WB: pc_jump = PCJEN & !err & (REGEN | br_taken); pc_target = alu_res with bit0 cleared when PCREN=0 (JALR), else alu_res.
REQ-027 rf_wen, pc_jump, done, err are zero in all states other than WB.
REQ-028 Latency: non-memory command accepted at cycle N -> WB at N+1; memory command with ack at cycle M -> WB at M+1; next accept earliest one cycle after WB.
REQ-029 Arithmetic mod 2^32; pc+4 wraps (0xFFFFFFFC -> 0x00000000).

Reset
REQ-030 rst_n low asynchronously forces IDLE, timeout counter 0, all captured registers 0, all outputs 0 except cmd_ready which is 1 after reset release.
REQ-031 Reset mid-MEM drops mem_req immediately; no done/rf_wen issued for the aborted command.

Verification
REQ-032 ADD-type cmd 0x2000 (REGEN), alu_res=0x1234 -> next cycle rf_wen=1, rf_wdata=0x1234, done=1, err=0.
REQ-033 LB (MREN=01,UNSIGN=0), alu_res=0x103, mem_rdata=0x80FF_FFFF, ack after 3 cycles -> mem_addr=0x100, rf_wdata=0xFFFFFF80; LBU same -> 0x00000080.
REQ-034 SH, alu_res=0x202, rs2=0xABCD1234 -> mem_we=1, mem_wstrb=4'b1100, mem_wdata=0x12341234, rf_wen=0.
REQ-035 LW with alu_res=0x2 -> no mem_req, WB err=1, rf_wen=0; LW with no ack, TIMEOUT=4 -> err=1 after 4 MEM cycles; ack on 4th cycle -> err=0.
REQ-036 JALR (REGEN,PCJEN,PCREN=0), pc=0x80000000, alu_res=0x80000101 -> rf_wdata=0x80000004, pc_jump=1, pc_target=0x80000100; BEQ with br_taken=0 -> pc_jump=0.
REQ-037 rst_n asserted during MEM -> mem_req=0 same cycle, cmd_ready=1 after release, no done pulse.
